// File: rtl/move_sel_pkg.sv
// Shared types and constants for the move-selection blocks.
package move_sel_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic SEL_MAX   = 1'b0;
    localparam logic SEL_MIN   = 1'b1;
    localparam logic TIE_FIRST = 1'b0;
    localparam logic TIE_LAST  = 1'b1;

    localparam int SCORE_W_DEF = 6;
    localparam int POS_W_DEF   = 6;
endpackage

// File: rtl/move_argmax_stream_if.sv
// Candidate stream in, selected result out, each with its own valid/ready pair.
interface move_argmax_stream_if #(
    parameter int SCORE_W = 6,
    parameter int POS_W   = 6,
    parameter int CNT_W   = 7
);
    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic [POS_W-1:0]   in_pos;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [SCORE_W-1:0] out_score;
    logic [POS_W-1:0]   out_pos;
    logic [CNT_W-1:0]   out_count;
    logic               out_trunc;

    modport master (
        output in_valid, in_score, in_pos, in_last, out_ready,
        input  in_ready, out_valid, out_score, out_pos, out_count, out_trunc
    );
    modport slave (
        input  in_valid, in_score, in_pos, in_last, out_ready,
        output in_ready, out_valid, out_score, out_pos, out_count, out_trunc
    );
endinterface

// File: rtl/argmax_cmp.sv
// Single compare cell: does the candidate replace the current best?
module argmax_cmp
    import move_sel_pkg::*;
#(
    parameter int W = SCORE_W_DEF
) (
    input  logic [W-1:0] cand,
    input  logic [W-1:0] best,
    input  logic         mode_min,
    input  logic         tie_last,
    output logic         take
);
    logic better, equal;

    assign better = (mode_min == SEL_MIN) ? (cand < best) : (cand > best);
    assign equal  = (cand == best);
    assign take   = better || (equal && tie_last == TIE_LAST);
endmodule

// File: rtl/move_argmax_stream.sv
// Streaming arg-max/arg-min over one frame of (score, pos) candidates.
module move_argmax_stream
    import move_sel_pkg::*;
#(
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int MAX_CAND = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mode_min,
    input  logic tie_last,
    input  logic abort,
    move_argmax_stream_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_CAND + 1);

    state_t             state;
    logic               sel_min, sel_tie, first;
    logic [CNT_W-1:0]   count;
    logic [SCORE_W-1:0] best_score;
    logic [POS_W-1:0]   best_pos;

    logic               take, upd, accept, close;
    logic [CNT_W-1:0]   count_nxt;
    logic [SCORE_W-1:0] new_score;
    logic [POS_W-1:0]   new_pos;

    argmax_cmp #(.W(SCORE_W)) u_cmp (
        .cand     (bus.in_score),
        .best     (best_score),
        .mode_min (sel_min),
        .tie_last (sel_tie),
        .take     (take)
    );

    assign bus.in_ready = (state == COLLECT);
    assign accept    = bus.in_valid && (state == COLLECT);
    assign upd       = first || take;
    assign count_nxt = count + 1'b1;
    assign close     = accept && (bus.in_last || count_nxt == CNT_W'(MAX_CAND));
    assign new_score = upd ? bus.in_score : best_score;
    assign new_pos   = upd ? bus.in_pos   : best_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sel_min       <= SEL_MAX;
            sel_tie       <= TIE_FIRST;
            first         <= 1'b1;
            count         <= '0;
            best_score    <= '0;
            best_pos      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_score <= '0;
            bus.out_pos   <= '0;
            bus.out_count <= '0;
            bus.out_trunc <= 1'b0;
        end else if (abort) begin
            // Result registers are deliberately left as-is; out_valid qualifies them.
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sel_min <= mode_min;
                    sel_tie <= tie_last;
                    count   <= '0;
                    first   <= 1'b1;
                    state   <= COLLECT;
                end
                COLLECT: if (accept) begin
                    first      <= 1'b0;
                    count      <= count_nxt;
                    best_score <= new_score;
                    best_pos   <= new_pos;
                    if (close) begin
                        bus.out_score <= new_score;
                        bus.out_pos   <= new_pos;
                        bus.out_count <= count_nxt;
                        bus.out_trunc <= !bus.in_last;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_argmax_stream.sv
// Bench for move_argmax_stream: fixed vectors, corner sequences, random frames vs model.
module tb_move_argmax_stream;
    localparam int SW = 6;
    localparam int PW = 6;
    localparam int MC = 64;
    localparam int CW = $clog2(MC + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, mode_min = 1'b0, tie_last = 1'b0, abort = 1'b0;

    move_argmax_stream_if #(.SCORE_W(SW), .POS_W(PW), .CNT_W(CW)) bus();

    move_argmax_stream #(.SCORE_W(SW), .POS_W(PW), .MAX_CAND(MC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode_min (mode_min),
        .tie_last (tie_last),
        .abort    (abort),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sc[64];
    int ps[64];

    typedef struct {
        bit             mm;
        bit             tl;
        int             n;
        logic [3:0][7:0] s;
        logic [3:0][7:0] p;
        int             es;
        int             ep;
        int             ec;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: find the extreme value first, then pick its first or last occurrence.
    task automatic model(input int n, input bit mm, input bit tl, output int es, output int ep);
        int best = sc[0];
        ep = ps[0];
        for (int i = 1; i < n; i++)
            if (mm ? (sc[i] < best) : (sc[i] > best)) best = sc[i];
        for (int i = 0; i < n; i++)
            if (sc[i] == best) begin
                ep = ps[i];
                if (!tl) break;
            end
        es = best;
    endtask

    task automatic open_frame(input bit mm, input bit tl);
        @(posedge clk); #1;
        start = 1'b1; mode_min = mm; tie_last = tl;
        @(posedge clk); #1;
        start = 1'b0; mode_min = 1'($urandom); tie_last = 1'($urandom);
    endtask

    task automatic send_beats(input int n, input bit with_last, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_score = sc[i][SW-1:0];
            bus.in_pos   = ps[i][PW-1:0];
            bus.in_last  = with_last && (i == n - 1);
            if (i == 0) chk("ready_in_collect", int'(bus.in_ready), 1);
            if (i == n - 1) chk("valid_before_close", int'(bus.out_valid), 0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            bus.in_score = SW'($urandom);
        end
    endtask

    task automatic check_result(input string tag, input int es, input int ep, input int ec, input int et);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_score"}, int'(bus.out_score), es);
        chk({tag, "_pos"},   int'(bus.out_pos), ep);
        chk({tag, "_count"}, int'(bus.out_count), ec);
        chk({tag, "_trunc"}, int'(bus.out_trunc), et);
    endtask

    task automatic close_hs();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("hs_idle_valid", int'(bus.out_valid), 0);
        chk("hs_idle_ready", int'(bus.in_ready), 0);
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < tbl[k].n; i++) begin
            sc[i] = int'(tbl[k].s[i]);
            ps[i] = int'(tbl[k].p[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int es, ep, n;
        bit wl, mm, tl;

        tbl[0] = '{mm:1'b0, tl:1'b0, n:4, s:{8'd12, 8'd7, 8'd12, 8'd5}, p:{8'd40, 8'd30, 8'd20, 8'd10}, es:12, ep:20, ec:4};
        tbl[1] = '{mm:1'b0, tl:1'b1, n:4, s:{8'd12, 8'd7, 8'd12, 8'd5}, p:{8'd40, 8'd30, 8'd20, 8'd10}, es:12, ep:40, ec:4};
        tbl[2] = '{mm:1'b1, tl:1'b0, n:4, s:{8'd12, 8'd7, 8'd12, 8'd5}, p:{8'd40, 8'd30, 8'd20, 8'd10}, es:5,  ep:10, ec:4};
        tbl[3] = '{mm:1'b1, tl:1'b1, n:4, s:{8'd9, 8'd3, 8'd3, 8'd5},   p:{8'd4, 8'd3, 8'd2, 8'd1},     es:3,  ep:3,  ec:4};

        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_score = '0; bus.in_pos = '0; bus.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", int'(bus.in_ready), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_score", int'(bus.out_score), 0);
        chk("rst_pos",   int'(bus.out_pos), 0);
        chk("rst_count", int'(bus.out_count), 0);
        chk("rst_trunc", int'(bus.out_trunc), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Fixed vectors
        for (int k = 0; k < 4; k++) begin
            load_vec(k);
            open_frame(tbl[k].mm, tbl[k].tl);
            send_beats(tbl[k].n, 1'b1, 1);
            check_result($sformatf("vec%0d", k), tbl[k].es, tbl[k].ep, tbl[k].ec, 0);
            close_hs();
        end

        // Limit close: 64 ascending scores, never in_last
        for (int i = 0; i < 64; i++) begin sc[i] = i; ps[i] = i; end
        open_frame(1'b0, 1'b0);
        send_beats(64, 1'b0, 0);
        check_result("trunc", 63, 63, 64, 1);
        close_hs();

        // Backpressure with an ignored start pulse
        load_vec(0);
        open_frame(1'b0, 1'b0);
        send_beats(4, 1'b1, 0);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            @(posedge clk); #1;
            start = 1'b0;
            check_result("hold", 12, 20, 4, 0);
        end
        // start coinciding with the handshake must not reopen a frame
        start = 1'b1;
        close_hs();
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_ignored_ready", int'(bus.in_ready), 0);

        // Abort on an accepted mid-frame beat
        sc[0] = 4; ps[0] = 1; sc[1] = 8; ps[1] = 2;
        open_frame(1'b0, 1'b0);
        send_beats(2, 1'b0, 0);
        bus.in_valid = 1'b1; bus.in_score = 6'd60; bus.in_pos = 6'd5; bus.in_last = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("abort_ready", int'(bus.in_ready), 0);
        chk("abort_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk("abort_valid2", int'(bus.out_valid), 0);
        sc[0] = 3; ps[0] = 9;
        open_frame(1'b0, 1'b0);
        send_beats(1, 1'b1, 0);
        check_result("single", 3, 9, 1, 0);

        // Abort while holding a result: valid drops, result registers retained
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_hold_valid", int'(bus.out_valid), 0);
        chk("abort_hold_score", int'(bus.out_score), 3);
        chk("abort_hold_ready", int'(bus.in_ready), 0);

        // Random frames against the model
        for (int f = 0; f < 30; f++) begin
            n  = (f % 6 == 5) ? 64 : int'($urandom_range(64, 1));
            wl = (n < 64) ? 1'b1 : 1'($urandom);
            mm = 1'($urandom);
            tl = 1'($urandom);
            for (int i = 0; i < n; i++) begin
                sc[i] = (f % 2 == 0) ? int'($urandom_range(7, 0)) : int'($urandom_range(63, 0));
                ps[i] = int'($urandom_range(63, 0));
            end
            model(n, mm, tl, es, ep);
            open_frame(mm, tl);
            send_beats(n, wl, 2);
            check_result($sformatf("rand%0d", f), es, ep, n, int'(!wl));
            close_hs();
        end

        // Async reset in the middle of a frame
        for (int i = 0; i < 3; i++) begin sc[i] = 10 + i; ps[i] = i; end
        open_frame(1'b0, 1'b0);
        send_beats(3, 1'b0, 0);
        bus.in_valid = 1'b1; bus.in_score = 6'd20;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(bus.in_ready), 0);
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_count", int'(bus.out_count), 0);
        bus.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Recovery after reset
        load_vec(1);
        open_frame(1'b0, 1'b1);
        send_beats(4, 1'b1, 0);
        check_result("post_rst", 12, 40, 4, 0);
        close_hs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
